instr_prefetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the pipeline's IF/ID register. It replaces the zero-latency PC/instruction-memory path with a request/acknowledge fetch port, and buffers fetched {pc, instr} pairs in a small FIFO. It presents the queue head to the IF/ID stage and flushes on a branch redirect from EX/MEM.

---
 rtl/instr_prefetch_queue_if.sv | 30 +++
 rtl/instr_prefetch_queue.sv | 143 ++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bundle of the prefetch queue: memory port, IF/ID head port and redirect.
// master = queue side, slave = memory/pipeline side.
interface instr_prefetch_queue_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redirect;
    logic [63:0] redirect_pc;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: req/ack fetch port feeding a {pc,instr} FIFO.
// Optional IFQ_PERF_CNT_EN adds fetch/flush performance counters.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input logic                    clk,
    input logic                    reset,
    instr_prefetch_queue_if.master bus
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   req_addr_q, req_addr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [63:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic          push;
    logic          pop;
    logic          has_room;

    assign pop      = (count_q != '0) & bus.if_ready & ~bus.redirect;
    assign has_room = (count_q != FULL) | pop;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.redirect && has_room) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    if (!bus.redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 64'd4;
                    end
                end else if (bus.redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirect) fetch_pc_d = bus.redirect_pc;
    end

    // redirect wins over any push/pop in the same cycle
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= req_addr_q;
            instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req  = (state_q == WAIT) | (state_q == DISCARD);
    assign bus.mem_addr = req_addr_q;
    assign bus.if_valid = (count_q != '0) & ~bus.redirect;
    assign bus.if_pc    = pc_mem_q[rd_ptr_q];
    assign bus.if_instr = instr_mem_q[rd_ptr_q];

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_inc;

    // in-flight data is counted once, when the WAIT request gets orphaned
    assign flush_inc = 32'(count_q) + {31'd0, state_q == WAIT};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)         fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (bus.redirect) flush_cnt_q <= flush_cnt_q + flush_inc;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: vector table, directed redirect/reset
// sequences and a random run against a queue-based reference model.
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'd0;

    logic clk = 1'b0;
    logic reset;

    instr_prefetch_queue_if bus ();

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference model: a queue of fetched entries plus one in-flight request
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy;
    bit          m_stale;
    logic [63:0] m_req;
    logic [63:0] m_next;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    bit          c_rdy;
    bit          c_rd;
    logic [63:0] c_rpc;
    bit          c_ack;
    logic [31:0] c_rdata;
    bit          c_vexp;

    task automatic model_reset();
        mq.delete();
        m_busy  = 0;
        m_stale = 0;
        m_req   = RESET_PC;
        m_next  = RESET_PC;
        m_fetch = '0;
        m_flush = '0;
    endtask

    task automatic idle_inputs();
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    // called at a negedge; returns at a negedge with reset released
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_chk(input bit rdy, input bit rd, input logic [63:0] rpc,
                             input bit ack, input logic [31:0] rdata);
        c_rdy = rdy; c_rd = rd; c_rpc = rpc; c_ack = ack; c_rdata = rdata;
        bus.if_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.mem_ack     = ack;
        bus.mem_rdata   = rdata;
        #1;
        c_vexp = (mq.size() != 0) && !rd;
        chk("mem_req", bus.mem_req, m_busy);
        chk("mem_addr", bus.mem_addr, m_req);
        chk("if_valid", bus.if_valid, c_vexp);
        if (c_vexp) begin
            chk("if_pc", bus.if_pc, mq[0].pc);
            chk("if_instr", bus.if_instr, mq[0].instr);
        end
`ifdef IFQ_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_flush", perf_flush_cnt, m_flush);
`endif
    endtask

    task automatic adv();
        bit pop;
        bit issue;
        pop = c_vexp && c_rdy;
        if (c_rd) begin
            m_flush += 32'(mq.size()) + 32'(m_busy && !m_stale);
            mq.delete();
            m_next = c_rpc;
            if (m_busy) begin
                if (c_ack) begin
                    m_busy  = 0;
                    m_stale = 0;
                end else begin
                    m_stale = 1;
                end
            end
        end else begin
            issue = !m_busy && ((mq.size() - int'(pop)) < DEPTH);
            if (pop) void'(mq.pop_front());
            if (m_busy && c_ack) begin
                if (!m_stale) begin
                    mq.push_back('{pc: m_req, instr: c_rdata});
                    m_next  = m_next + 64'd4;
                    m_fetch = m_fetch + 32'd1;
                end
                m_busy  = 0;
                m_stale = 0;
            end else if (issue) begin
                m_busy = 1;
                m_req  = m_next;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input bit rdy, input bit rd, input logic [63:0] rpc,
                        input bit ack, input logic [31:0] rdata);
        drive_chk(rdy, rd, rpc, ack, rdata);
        adv();
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          ack;
        logic [31:0] rdata;
        bit          req;
        logic [63:0] addr;
        bit          valid;
        logic [63:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit rst, bit rdy, bit ack, logic [31:0] rdata,
                                bit req, logic [63:0] addr, bit valid,
                                logic [63:0] pc, logic [31:0] instr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
        return v;
    endfunction

    initial begin
        logic [63:0] rpc;

        // streaming with immediate ack and a ready consumer
        tbl[0]  = mk(1, 1, 0, 0,            0, 64'h0,  0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 32'h00000013, 1, 64'h0,  0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0,            0, 64'h0,  1, 64'h0, 32'h00000013);
        tbl[3]  = mk(0, 1, 1, 32'h00A00093, 1, 64'h4,  0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0,            0, 64'h4,  1, 64'h4, 32'h00A00093);
        tbl[5]  = mk(0, 1, 1, 32'h00B00113, 1, 64'h8,  0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0,            0, 64'h8,  1, 64'h8, 32'h00B00113);
        // stalled consumer fills the queue, then one pop re-opens fetch
        tbl[7]  = mk(1, 0, 0, 0,            0, 64'h0,  0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 32'hE0000000, 1, 64'h0,  0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0,            0, 64'h0,  1, 64'h0, 32'hE0000000);
        tbl[10] = mk(0, 0, 1, 32'hE0000001, 1, 64'h4,  1, 64'h0, 32'hE0000000);
        tbl[11] = mk(0, 0, 0, 0,            0, 64'h4,  1, 64'h0, 32'hE0000000);
        tbl[12] = mk(0, 0, 1, 32'hE0000002, 1, 64'h8,  1, 64'h0, 32'hE0000000);
        tbl[13] = mk(0, 0, 0, 0,            0, 64'h8,  1, 64'h0, 32'hE0000000);
        tbl[14] = mk(0, 0, 1, 32'hE0000003, 1, 64'hC,  1, 64'h0, 32'hE0000000);
        tbl[15] = mk(0, 0, 0, 0,            0, 64'hC,  1, 64'h0, 32'hE0000000);
        tbl[16] = mk(0, 0, 0, 0,            0, 64'hC,  1, 64'h0, 32'hE0000000);
        tbl[17] = mk(0, 1, 0, 0,            0, 64'hC,  1, 64'h0, 32'hE0000000);
        tbl[18] = mk(0, 0, 0, 0,            1, 64'h10, 1, 64'h4, 32'hE0000001);

        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].rst) do_reset();
            bus.if_ready  = tbl[i].rdy;
            bus.mem_ack   = tbl[i].ack;
            bus.mem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), bus.mem_req, tbl[i].req);
            chk($sformatf("v%0d_addr", i), bus.mem_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), bus.if_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("v%0d_pc", i), bus.if_pc, tbl[i].pc);
                chk($sformatf("v%0d_instr", i), bus.if_instr, tbl[i].instr);
            end
            @(negedge clk);
        end

        // redirect with three queued entries
        do_reset();
        for (int k = 0; k < 6; k++) step(0, 0, 0, k[0], 32'hC0 + 32'(k));
        drive_chk(0, 1, 64'h100, 0, 0);
        chk("t3_valid_redir", bus.if_valid, 0);
        adv();
        step(1, 0, 0, 0, 0);
        drive_chk(1, 0, 0, 1, 32'hD100);
        chk("t3_addr", bus.mem_addr, 64'h100);
        adv();
        drive_chk(1, 0, 0, 0, 0);
        chk("t3_pc", bus.if_pc, 64'h100);
        adv();

        // redirect while waiting on 0x8 with a late ack
        do_reset();
        for (int k = 0; k < 5; k++) step(0, 0, 0, k[0], 32'hA0 + 32'(k));
        drive_chk(0, 1, 64'h200, 0, 0);
        chk("t4_addr_redir", bus.mem_addr, 64'h8);
        adv();
        for (int k = 0; k < 2; k++) begin
            drive_chk(0, 0, 0, 0, 0);
            chk("t4_hold_addr", bus.mem_addr, 64'h8);
            chk("t4_hold_req", bus.mem_req, 1);
            adv();
        end
        drive_chk(0, 0, 0, 1, 32'hDEAD);
        chk("t4_ack_addr", bus.mem_addr, 64'h8);
        adv();
        step(1, 0, 0, 0, 0);
        drive_chk(1, 0, 0, 1, 32'h200A);
        chk("t4_new_addr", bus.mem_addr, 64'h200);
        adv();
        drive_chk(1, 0, 0, 0, 0);
        chk("t4_instr", bus.if_instr, 32'h200A);
        adv();

        // redirect coinciding with ack and pop
        do_reset();
        for (int k = 0; k < 7; k++) step(0, 0, 0, k[0], 32'hB0 + 32'(k));
        step(1, 1, 64'h300, 1, 32'hBAD);
        drive_chk(0, 0, 0, 0, 0);
        chk("t5_valid", bus.if_valid, 0);
        chk("t5_req", bus.mem_req, 0);
        adv();
        drive_chk(0, 0, 0, 0, 0);
        chk("t5_addr", bus.mem_addr, 64'h300);
        adv();

        // reset while a request is outstanding, stray ack afterwards
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        drive_chk(1, 0, 0, 1, 32'hBEEF);
        chk("t6_req", bus.mem_req, 0);
        chk("t6_addr_rst", bus.mem_addr, RESET_PC);
`ifdef IFQ_PERF_CNT_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 0);
        chk("t6_perf_flush", perf_flush_cnt, 0);
`endif
        adv();
        drive_chk(1, 0, 0, 0, 0);
        chk("t6_valid", bus.if_valid, 0);
        chk("t6_addr", bus.mem_addr, RESET_PC);
        adv();

        // random traffic, including redirects near the top of the address space
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            else rpc = {$urandom, $urandom} & ~64'h3;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc,
                 $urandom_range(0, 2) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
